// File: rtl/seq_memory_game.sv
// Simon-style memory game core: grows a random pattern sequence one entry per level,
// replays it on the LEDs with per-level speed-up, then scores player entries against it.
module seq_memory_game #(
    parameter int N_LEDS    = 8,
    parameter int MAX_DEPTH = 16,
    parameter int SHOW_CYC  = 50000000,
    parameter int GAP_CYC   = 12500000,
    parameter int STEP_CYC  = 2500000,
    parameter int MIN_SHOW  = 5000000,
    parameter int LIVES     = 3,
    parameter int SCORE_W   = 8,
    localparam int LVL_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               btn_enter_i,
    input  logic [N_LEDS-1:0]  sw_i,
    input  logic [N_LEDS-1:0]  rng_val_i,
    output logic [N_LEDS-1:0]  led_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [LVL_W-1:0]   level_o,
    output logic [2:0]         lives_o,
    output logic               busy_show_o,
    output logic               game_over_o,
    output logic               game_won_o
);
    // state      | meaning
    // S_IDLE     | waiting for Enter to start a game
    // S_GEN      | append a new random entry at seq[level]
    // S_SHOW_ON  | display seq[idx] for the level's show time
    // S_SHOW_OFF | blank gap between displayed entries
    // S_INPUT    | echo switches, evaluate each Enter against seq[idx]
    // S_LOST     | out of lives, LEDs blink, waiting for restart
    // S_WON      | full sequence completed, LEDs lit, waiting for restart
    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_LOST, S_WON
    } state_t;

    localparam int TMR_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [2:0]          lives_q, lives_d;
    logic                blink_q, blink_d;
    logic                btn_q;
    logic [N_LEDS-1:0]   seq_q [MAX_DEPTH];

    logic                enter;
    logic                seq_we;
    logic [N_LEDS-1:0]   seq_wdata;
    logic [31:0]         show_red;
    logic [31:0]         show_len;
    logic [TMR_W-1:0]    show_load;
    logic [TMR_W-1:0]    gap_load;
    logic                idx_last;

    assign enter     = btn_enter_i & ~btn_q;
    assign seq_wdata = (rng_val_i == '0) ? N_LEDS'(1) : rng_val_i;
    assign idx_last  = (LVL_W'(idx_q) == level_q);

    // Show time shrinks per level; compare before subtracting so it never underflows.
    always_comb begin
        show_red = 32'(level_q) * 32'(STEP_CYC);
        if (show_red + 32'(MIN_SHOW) >= 32'(SHOW_CYC))
            show_len = 32'(MIN_SHOW);
        else
            show_len = 32'(SHOW_CYC) - show_red;
        show_load = TMR_W'(show_len - 32'd1);
        gap_load  = TMR_W'(GAP_CYC - 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            level_q <= '0;
            score_q <= '0;
            lives_q <= 3'(LIVES);
            blink_q <= 1'b0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            score_q <= score_d;
            lives_q <= lives_d;
            blink_q <= blink_d;
            btn_q   <= btn_enter_i;
        end
    end

    // Sequence storage needs no reset: entries above the current level are never read.
    always_ff @(posedge clk_i) begin
        if (seq_we)
            seq_q[level_q[IDX_W-1:0]] <= seq_wdata;
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        level_d = level_q;
        score_d = score_q;
        lives_d = lives_q;
        blink_d = blink_q;
        seq_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enter) begin
                    state_d = S_GEN;
                    timer_d = '0;
                end
            end
            S_GEN: begin
                seq_we  = 1'b1;
                idx_d   = '0;
                state_d = S_SHOW_ON;
                timer_d = show_load;
            end
            S_SHOW_ON: begin
                if (timer_q == '0) begin
                    state_d = S_SHOW_OFF;
                    timer_d = gap_load;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_SHOW_OFF: begin
                if (timer_q == '0) begin
                    if (idx_last) begin
                        state_d = S_INPUT;
                        idx_d   = '0;
                        timer_d = '0;
                    end else begin
                        state_d = S_SHOW_ON;
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = show_load;
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_INPUT: begin
                if (enter) begin
                    if (sw_i == seq_q[idx_q]) begin
                        if (score_q != {SCORE_W{1'b1}})
                            score_d = score_q + SCORE_W'(1);
                        if (!idx_last) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else if (level_q == LVL_W'(MAX_DEPTH - 1)) begin
                            state_d = S_WON;
                            timer_d = '0;
                        end else begin
                            level_d = level_q + LVL_W'(1);
                            state_d = S_GEN;
                            timer_d = '0;
                        end
                    end else if (lives_q == 3'd1) begin
                        lives_d = 3'd0;
                        state_d = S_LOST;
                        timer_d = gap_load;
                        blink_d = 1'b1;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        idx_d   = '0;
                        state_d = S_SHOW_ON;
                        timer_d = show_load;
                    end
                end
            end
            S_LOST, S_WON: begin
                if (enter) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                    idx_d   = '0;
                    level_d = '0;
                    score_d = '0;
                    lives_d = 3'(LIVES);
                    blink_d = 1'b0;
                end else if (state_q == S_LOST) begin
                    if (timer_q == '0) begin
                        blink_d = ~blink_q;
                        timer_d = gap_load;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        led_o = '0;
        case (state_q)
            S_SHOW_ON: led_o = seq_q[idx_q];
            S_INPUT:   led_o = sw_i;
            S_LOST:    led_o = blink_q ? '1 : '0;
            S_WON:     led_o = '1;
            default:   led_o = '0;
        endcase
    end

    assign score_o     = score_q;
    assign level_o     = level_q;
    assign lives_o     = lives_q;
    assign busy_show_o = (state_q == S_SHOW_ON) || (state_q == S_SHOW_OFF);
    assign game_over_o = (state_q == S_LOST) || (state_q == S_WON);
    assign game_won_o  = (state_q == S_WON);
endmodule

// File: tb/tb_seq_memory_game.sv
// Bench for seq_memory_game: a game model predicts LED frames (scoreboard queue) and
// score/level/lives after each entry; a second instance with a 2-bit score checks saturation.
module tb_seq_memory_game;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, btn;
    logic [7:0] sw, rng;
    logic [7:0] led, led2, score;
    logic [1:0] score2;
    logic [2:0] level, level2, lives, lives2;
    logic       busy, busy2, over, over2, won, won2;

    seq_memory_game #(.N_LEDS(8), .MAX_DEPTH(4), .SHOW_CYC(8), .GAP_CYC(2), .STEP_CYC(2),
                      .MIN_SHOW(4), .LIVES(2), .SCORE_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .btn_enter_i(btn), .sw_i(sw), .rng_val_i(rng),
        .led_o(led), .score_o(score), .level_o(level), .lives_o(lives),
        .busy_show_o(busy), .game_over_o(over), .game_won_o(won));

    seq_memory_game #(.N_LEDS(8), .MAX_DEPTH(4), .SHOW_CYC(8), .GAP_CYC(2), .STEP_CYC(2),
                      .MIN_SHOW(4), .LIVES(2), .SCORE_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .btn_enter_i(btn), .sw_i(sw), .rng_val_i(rng),
        .led_o(led2), .score_o(score2), .level_o(level2), .lives_o(lives2),
        .busy_show_o(busy2), .game_over_o(over2), .game_won_o(won2));

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_seq[$];
    logic [7:0] sb_led[$];
    int m_score, m_level, m_lives;
    bit m_won;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int t_show(int lvl);
        int t;
        t = 8 - 2 * lvl;
        return (t > 4) ? t : 4;
    endfunction

    function automatic logic [1:0] sat2(int s);
        return (s > 3) ? 2'd3 : 2'(s);
    endfunction

    task automatic press(input int hold);
        btn = 1'b1;
        repeat (hold) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic start_game(input logic [7:0] r);
        rng = r;
        @(negedge clk);
        press(1);
        exp_seq.push_back((r == 8'h00) ? 8'h01 : r);
    endtask

    task automatic watch_show(input bit poke);
        int n;
        int k;
        logic [7:0] e;
        for (int i = 0; i <= m_level; i++) begin
            repeat (t_show(m_level)) sb_led.push_back(exp_seq[i]);
            repeat (2) sb_led.push_back(8'h00);
        end
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL show_start: busy_show=%b expected 1", busy);
            sb_led.delete();
        end
        k = 0;
        while (sb_led.size() > 0) begin
            e = sb_led.pop_front();
            checks++;
            if (led !== e) begin
                failures++;
                $display("FAIL show_led: level %0d frame %0d led=%h expected %h", m_level, k, led, e);
            end
            btn = poke && (k % 3 == 1) && (sb_led.size() > 2);
            k++;
            @(negedge clk);
        end
        btn = 1'b0;
        checks++;
        if ({busy, led} !== {1'b0, sw}) begin
            failures++;
            $display("FAIL show_end: busy=%b led=%h expected busy=0 led=%h", busy, led, sw);
        end
    endtask

    task automatic play_level(input logic [7:0] nxt, input int hold, input bit poke);
        int lvl;
        watch_show(poke);
        lvl = m_level;
        for (int i = 0; i <= lvl; i++) begin
            sw = exp_seq[i];
            if (i == lvl) rng = nxt;
            @(negedge clk);
            press((i == 0) ? hold : 1);
            m_score++;
            if (i == lvl) begin
                if (m_level == 3) m_won = 1'b1;
                else begin
                    m_level++;
                    exp_seq.push_back((nxt == 8'h00) ? 8'h01 : nxt);
                end
            end
            checks++;
            if ({score, level, lives, over, won} !== {8'(m_score), 3'(m_level), 3'(m_lives), m_won, m_won}) begin
                failures++;
                $display("FAIL entry_status: score=%0d level=%0d lives=%0d over=%b won=%b expected %0d %0d %0d %b %b",
                         score, level, lives, over, won, m_score, m_level, m_lives, m_won, m_won);
            end
            checks++;
            if (score2 !== sat2(m_score)) begin
                failures++;
                $display("FAIL sat_score: score=%0d expected %0d", score2, sat2(m_score));
            end
        end
    endtask

    task automatic model_reset();
        m_score = 0; m_level = 0; m_lives = 2; m_won = 1'b0;
        exp_seq.delete();
        sb_led.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = 1'b0; sw = 8'h00; rng = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({led, score, level, lives, busy, over, won} !== {8'h00, 8'd0, 3'd0, 3'd2, 3'b000}) begin
            failures++;
            $display("FAIL reset: led=%h score=%0d level=%0d lives=%0d busy=%b over=%b won=%b",
                     led, score, level, lives, busy, over, won);
        end
    endtask

    task automatic test_first_level();
        start_game(8'hA5);
        play_level(8'h00, 1, 1'b0);
        checks++;
        if ({score, level} !== {8'd1, 3'd1}) begin
            failures++;
            $display("FAIL first_level: score=%0d level=%0d expected 1 1", score, level);
        end
    endtask

    task automatic test_miss_to_lost();
        logic [7:0] blink_exp [6];
        blink_exp = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
        watch_show(1'b0);
        sw = 8'h5A;
        @(negedge clk);
        press(1);
        m_lives = 1;
        checks++;
        if ({score, level, lives, busy, over} !== {8'd1, 3'd1, 3'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL first_miss: score=%0d level=%0d lives=%0d busy=%b over=%b expected 1 1 1 1 0",
                     score, level, lives, busy, over);
        end
        watch_show(1'b0);
        @(negedge clk);
        press(1);
        checks++;
        if ({score, level, lives, over, won} !== {8'd1, 3'd1, 3'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL lost: score=%0d level=%0d lives=%0d over=%b won=%b expected 1 1 0 1 0",
                     score, level, lives, over, won);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({led, score, lives} !== {blink_exp[i], 8'd1, 3'd0}) begin
                failures++;
                $display("FAIL lost_blink: cycle %0d led=%h score=%0d lives=%0d expected %h 1 0",
                         i, led, score, lives, blink_exp[i]);
            end
            @(negedge clk);
        end
        press(1);
        model_reset();
        checks++;
        if ({led, score, level, lives, busy, over, won} !== {8'h00, 8'd0, 3'd0, 3'd2, 3'b000}) begin
            failures++;
            $display("FAIL lost_restart: led=%h score=%0d level=%0d lives=%0d over=%b",
                     led, score, level, lives, over);
        end
    endtask

    task automatic test_win_hold_poke();
        start_game(8'h3C);
        play_level(8'hC3, 1, 1'b0);
        play_level(8'h7E, 20, 1'b0);
        play_level(8'h81, 1, 1'b1);
        play_level(8'h00, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({led, score, score2, over, won} !== {8'hFF, 8'd10, 2'd3, 1'b1, 1'b1}) begin
                failures++;
                $display("FAIL won: led=%h score=%0d sat_score=%0d over=%b won=%b expected FF 10 3 1 1",
                         led, score, score2, over, won);
            end
            @(negedge clk);
        end
        press(1);
        model_reset();
        checks++;
        if ({led, score, score2, level, lives, over, won} !== {8'h00, 8'd0, 2'd0, 3'd0, 3'd2, 2'b00}) begin
            failures++;
            $display("FAIL won_restart: led=%h score=%0d level=%0d lives=%0d over=%b won=%b",
                     led, score, level, lives, over, won);
        end
    endtask

    task automatic test_reset_mid_show();
        int n;
        @(negedge clk);
        start_game(8'h11);
        play_level(8'h22, 1, 1'b0);
        play_level(8'h33, 1, 1'b0);
        n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, led, level} !== {1'b1, 8'h11, 3'd2}) begin
            failures++;
            $display("FAIL pre_reset_show: busy=%b led=%h level=%0d expected 1 11 2", busy, led, level);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({led, score, level, lives, busy, over, won} !== {8'h00, 8'd0, 3'd0, 3'd2, 3'b000}) begin
            failures++;
            $display("FAIL mid_show_reset: led=%h score=%0d level=%0d lives=%0d busy=%b",
                     led, score, level, lives, busy);
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_first_level();
        test_miss_to_lost();
        test_win_hold_poke();
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
